// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard_pkg
//  Purpose  : Shared hazard definitions. Holds the latency classes, the
//             default register-address width and the encoding of the
//             ID-stage control mode with its decoder.
//  Revision : 1.0  initial release
// ============================================================================
package hazard_scoreboard_pkg;

    // Default geometry of the register file and of the scoreboard window
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_MAX_LAT    = 3;

    // Latency classes: cycles a result is not forwardable after leaving ID
    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = DEF_MAX_LAT;

    // What the ID stage does with its instruction this cycle
    typedef enum logic [1:0] {
        CTRL_RUN   = 2'd0,
        CTRL_STALL = 2'd1,
        CTRL_FLUSH = 2'd2
    } ctrl_mode_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic nop_control;
    } ctrl_out_t;

    // A flush keeps the front end moving but squashes ID; a stall freezes
    // the front end and inserts a bubble.
    function automatic ctrl_out_t ctrl_decode(input ctrl_mode_e mode);
        ctrl_out_t o;
        case (mode)
            CTRL_FLUSH: o = '{pc_write: 1'b1, ifid_write: 1'b1, nop_control: 1'b1};
            CTRL_STALL: o = '{pc_write: 1'b0, ifid_write: 1'b0, nop_control: 1'b1};
            default:    o = '{pc_write: 1'b1, ifid_write: 1'b1, nop_control: 1'b0};
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_reg_counter.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_reg_counter
//  Purpose  : Countdown of remaining non-forwardable cycles for one
//             architectural register. A load takes priority over the
//             decrement and is clamped to MAX_LAT.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_reg_counter #(
    parameter int MAX_LAT = 3,
    parameter int CNT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LAT);

    logic [CNT_W-1:0] load_sat;

    // Clamp the requested window to the largest supported latency
    always_comb begin
        load_sat = (load_val > MAX_C) ? MAX_C : load_val;
    end

    // Newest writer reloads the window; otherwise count down towards zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_sat;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : Load-use / multi-cycle hazard unit between ID and ID/EX.
//             Tracks per-register countdowns of results that cannot yet be
//             forwarded, stalls PC and IF/ID and injects a bubble while an
//             ID source is pending, and counts stall cycles.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int MAX_LAT    = DEF_MAX_LAT,
    parameter int CNT_W      = $clog2(MAX_LAT + 1),
    parameter int STAT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [REG_ADDR_W-1:0]      id_rs,
    input  logic [REG_ADDR_W-1:0]      id_rt,
    input  logic                       id_uses_rs,
    input  logic                       id_uses_rt,
    input  logic                       id_we,
    input  logic [REG_ADDR_W-1:0]      id_rd,
    input  logic [CNT_W-1:0]           id_lat,
    input  logic                       flush,
    output logic                       pc_write,
    output logic                       IFID_write,
    output logic                       nop_control,
    output logic [(2**REG_ADDR_W)-1:0] busy_vec,
    output logic [STAT_W-1:0]          stall_cycles
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic             hit_rs;
    logic             hit_rt;
    logic             stall;
    logic             issue;
    ctrl_mode_e       mode;
    ctrl_out_t        ctrl;

    // Register zero is hard-wired and can never be pending
    assign cnt[0]      = '0;
    assign busy_vec[0] = 1'b0;

    // Source operand hazards against the scoreboard
    always_comb begin
        hit_rs = id_valid & id_uses_rs & (id_rs != '0) & (cnt[id_rs] != '0);
        hit_rt = id_valid & id_uses_rt & (id_rt != '0) & (cnt[id_rt] != '0);
    end

    // Flush outranks stall; an instruction only issues when neither applies
    always_comb begin
        mode = CTRL_RUN;
        if (flush) begin
            mode = CTRL_FLUSH;
        end else if (hit_rs | hit_rt) begin
            mode = CTRL_STALL;
        end
        stall = (mode == CTRL_STALL);
        issue = id_valid & ~stall & ~flush;
        ctrl  = ctrl_decode(mode);
    end

    assign pc_write    = ctrl.pc_write;
    assign IFID_write  = ctrl.ifid_write;
    assign nop_control = ctrl.nop_control;

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg_cnt
            logic load_r;
            assign load_r = issue & id_we & (id_rd == REG_ADDR_W'(r));

            hazard_reg_counter #(
                .MAX_LAT (MAX_LAT),
                .CNT_W   (CNT_W)
            ) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .load     (load_r),
                .load_val (id_lat),
                .cnt      (cnt[r]),
                .busy     (busy_vec[r])
            );
        end
    endgenerate

    // Saturating count of cycles spent stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {STAT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + STAT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Purpose  : Directed self-checking bench for hazard_scoreboard. Each step
//             pushes the expected control triple to a queue when stimulus
//             is driven; it is popped and compared once outputs settle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int REG_ADDR_W = 5;
    localparam int MAX_LAT    = 3;
    localparam int CNT_W      = $clog2(MAX_LAT + 1);
    localparam int STAT_W     = 16;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    localparam int M_RUN   = 0;
    localparam int M_STALL = 1;
    localparam int M_FLUSH = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  id_we;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [CNT_W-1:0]      id_lat;
    logic                  flush;
    logic                  pc_write;
    logic                  IFID_write;
    logic                  nop_control;
    logic [NUM_REGS-1:0]   busy_vec;
    logic [STAT_W-1:0]     stall_cycles;

    typedef struct {
        string tag;
        logic  pc;
        logic  ifid;
        logic  nop;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    hazard_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .MAX_LAT    (MAX_LAT),
        .CNT_W      (CNT_W),
        .STAT_W     (STAT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_we        (id_we),
        .id_rd        (id_rd),
        .id_lat       (id_lat),
        .flush        (flush),
        .pc_write     (pc_write),
        .IFID_write   (IFID_write),
        .nop_control  (nop_control),
        .busy_vec     (busy_vec),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input int mode);
        exp_t e;
        e.tag  = tag;
        e.pc   = (mode != M_STALL);
        e.ifid = (mode != M_STALL);
        e.nop  = (mode != M_RUN);
        exp_q.push_back(e);
    endtask

    task automatic drive(input string tag, input logic v, input int rs, input int rt,
                         input logic urs, input logic urt, input logic we, input int rd,
                         input int lat, input logic fl, input int mode);
        id_valid   = v;
        id_rs      = REG_ADDR_W'(rs);
        id_rt      = REG_ADDR_W'(rt);
        id_uses_rs = urs;
        id_uses_rt = urt;
        id_we      = we;
        id_rd      = REG_ADDR_W'(rd);
        id_lat     = CNT_W'(lat);
        flush      = fl;
        push_exp(tag, mode);
    endtask

    task automatic sample_ctl();
        exp_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL queue_empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            vectors++;
            assert (pc_write === e.pc) else begin
                miscompares++;
                $error("FAIL %s pc_write observed=%0b expected=%0b", e.tag, pc_write, e.pc);
            end
            vectors++;
            assert (IFID_write === e.ifid) else begin
                miscompares++;
                $error("FAIL %s IFID_write observed=%0b expected=%0b", e.tag, IFID_write, e.ifid);
            end
            vectors++;
            assert (nop_control === e.nop) else begin
                miscompares++;
                $error("FAIL %s nop_control observed=%0b expected=%0b", e.tag, nop_control, e.nop);
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Drive, let combinational outputs settle, compare, then cross an edge
    task automatic step(input string tag, input logic v, input int rs, input int rt,
                        input logic urs, input logic urt, input logic we, input int rd,
                        input int lat, input logic fl, input int mode);
        drive(tag, v, rs, rt, urs, urt, we, rd, lat, fl, mode);
        #2;
        sample_ctl();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, M_RUN);
    endtask

    initial begin
        rst = 1'b1;
        drive("reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, M_RUN);
        repeat (2) @(posedge clk);
        #1;
        sample_ctl();
        check_val("reset_busy", 32'(busy_vec), 32'd0);
        check_val("reset_stat", 32'(stall_cycles), 32'd0);
        rst = 1'b0;
        #1;
        @(posedge clk);
        #1;

        // Load-use: one bubble
        step("lu_prod", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 5, 1, 1'b0, M_RUN);
        check_val("lu_busy5", 32'(busy_vec[5]), 32'd1);
        step("lu_stall", 1'b1, 5, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, M_STALL);
        step("lu_issue", 1'b1, 5, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, M_RUN);
        check_val("lu_stat", 32'(stall_cycles), 32'd1);

        // Multi-cycle: rt not used means no stall, then a real rt consumer
        step("mc_prod_a", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 7, 3, 1'b0, M_RUN);
        step("mc_nouse", 1'b1, 0, 7, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, M_RUN);
        step("mc_prod_b", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 7, 3, 1'b0, M_RUN);
        check_val("mc_busy7", 32'(busy_vec[7]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step("mc_stall", 1'b1, 0, 7, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, M_STALL);
        end
        step("mc_issue", 1'b1, 0, 7, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, M_RUN);
        check_val("mc_stat", 32'(stall_cycles), 32'd4);

        // WAW: a zero-latency rewrite clears the pending entry
        step("waw_long", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 9, 3, 1'b0, M_RUN);
        step("waw_alu", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 9, 0, 1'b0, M_RUN);
        check_val("waw_busy9", 32'(busy_vec[9]), 32'd0);
        step("waw_cons", 1'b1, 9, 9, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, M_RUN);

        // Register zero never becomes pending
        step("r0_prod", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 0, 3, 1'b0, M_RUN);
        check_val("r0_busy", 32'(busy_vec), 32'd0);
        step("r0_cons", 1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, M_RUN);

        // Flush during a stall: squash, keep counting down
        step("fl_prod", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 4, 3, 1'b0, M_RUN);
        step("fl_stall", 1'b1, 4, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, M_STALL);
        step("fl_flush", 1'b1, 4, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, M_FLUSH);
        check_val("fl_busy4", 32'(busy_vec[4]), 32'd1);
        check_val("fl_stat", 32'(stall_cycles), 32'd5);
        idle("fl_idle");
        check_val("fl_busy4_done", 32'(busy_vec[4]), 32'd0);

        // Flushed producer never sets its counter
        step("fl_prod_sq", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 6, 3, 1'b1, M_FLUSH);
        check_val("fl_busy6", 32'(busy_vec[6]), 32'd0);

        // Asynchronous reset in the middle of a stall
        step("ar_prod", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 3, 3, 1'b0, M_RUN);
        step("ar_stall1", 1'b1, 3, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, M_STALL);
        drive("ar_stall2", 1'b1, 3, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, M_STALL);
        #2;
        sample_ctl();
        check_val("ar_stat_pre", 32'(stall_cycles), 32'd6);
        #1;
        rst = 1'b1;
        #1;
        push_exp("ar_reset", M_RUN);
        sample_ctl();
        check_val("ar_busy", 32'(busy_vec), 32'd0);
        check_val("ar_stat", 32'(stall_cycles), 32'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step("ar_after", 1'b1, 3, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, M_RUN);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
